ps2_keycode_receiver: RTL and testbench

Receives PS/2 keyboard frames from the keyboard's open-collector clock/data lines and decodes them into single-cycle make-code pulses. It drives the 8-bit `keyboard` bus consumed by the sentence editor and the other scan-code consumers. Break sequences (F0 xx), prefixes (E0) and the Pause sequence are resolved internally. Downstream logic sees only make codes, with 0x00 meaning "no key this cycle".

---
 rtl/ps2_keycode_receiver.sv | 198 +++++++++++++++++++
 tb/tb_ps2_keycode_receiver.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_receiver.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 lines, checks frames and
// decodes make codes into one-cycle pulses. Optional macro: PS2_REPEAT_SUPPRESS_EN.
module ps2_keycode_receiver #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keyboard,
    output logic       key_valid,
    output logic       extended,
    output logic       frame_error
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RECEIVE = 2'd1;
    localparam logic [1:0] CHECK   = 2'd2;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_filt;
    logic          clk_filt_d;
    logic [FW-1:0] filt_cnt;
    logic          sample;
    logic          data_bit;

    logic [1:0]    state,    state_n;
    logic [3:0]    bit_cnt,  bit_cnt_n;
    logic [9:0]    shift,    shift_n;
    logic [TW-1:0] tmo_cnt,  tmo_cnt_n;
    logic          ext_flag, ext_flag_n;
    logic          brk_flag, brk_flag_n;
    logic [2:0]    skip_cnt, skip_cnt_n;
    logic [7:0]    keyboard_n;
    logic          key_valid_n;
    logic          extended_n;
    logic          frame_error_n;
    logic [7:0]    rx_code;
    logic          frame_ok;

    // Synchronisers idle high so reset never fabricates a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            data_sync  <= {data_sync[0], ps2_data};
            clk_filt_d <= clk_filt;
            if (clk_sync[1] != clk_filt) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    clk_filt <= clk_sync[1];
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign sample   = clk_filt_d & ~clk_filt;
    assign data_bit = data_sync[1];
    assign rx_code  = shift[7:0];
    assign frame_ok = (^shift[8:0]) & shift[9];

`ifdef PS2_REPEAT_SUPPRESS_EN
    // {ext, code} of the last emitted make; 9'h000 marks it invalid (0x00 is never emitted).
    logic [8:0] last_key, last_key_n;

    always_ff @(posedge clk) begin
        if (reset) last_key <= '0;
        else       last_key <= last_key_n;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            tmo_cnt     <= '0;
            ext_flag    <= 1'b0;
            brk_flag    <= 1'b0;
            skip_cnt    <= '0;
            keyboard    <= 8'h00;
            key_valid   <= 1'b0;
            extended    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            tmo_cnt     <= tmo_cnt_n;
            ext_flag    <= ext_flag_n;
            brk_flag    <= brk_flag_n;
            skip_cnt    <= skip_cnt_n;
            keyboard    <= keyboard_n;
            key_valid   <= key_valid_n;
            extended    <= extended_n;
            frame_error <= frame_error_n;
        end
    end

    // Frame FSM and scan-code decoder; tmo_cnt holds clocks since the last sample event.
    always_comb begin
        state_n       = state;
        bit_cnt_n     = bit_cnt;
        shift_n       = shift;
        tmo_cnt_n     = tmo_cnt;
        ext_flag_n    = ext_flag;
        brk_flag_n    = brk_flag;
        skip_cnt_n    = skip_cnt;
        keyboard_n    = 8'h00;
        key_valid_n   = 1'b0;
        extended_n    = 1'b0;
        frame_error_n = 1'b0;
`ifdef PS2_REPEAT_SUPPRESS_EN
        last_key_n    = last_key;
`endif
        case (state)
            IDLE: begin
                if (sample && !data_bit) begin
                    state_n   = RECEIVE;
                    bit_cnt_n = 4'd1;
                    tmo_cnt_n = TW'(1);
                end
            end
            RECEIVE: begin
                if (sample) begin
                    shift_n   = {data_bit, shift[9:1]};
                    bit_cnt_n = bit_cnt + 4'd1;
                    tmo_cnt_n = TW'(1);
                    if (bit_cnt == 4'd10) state_n = CHECK;
                end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    frame_error_n = 1'b1;
                    ext_flag_n    = 1'b0;
                    brk_flag_n    = 1'b0;
                    bit_cnt_n     = '0;
                    state_n       = IDLE;
                end else begin
                    tmo_cnt_n = tmo_cnt + TW'(1);
                end
            end
            CHECK: begin
                state_n   = IDLE;
                bit_cnt_n = '0;
                if (!frame_ok) begin
                    frame_error_n = 1'b1;
                    ext_flag_n    = 1'b0;
                    brk_flag_n    = 1'b0;
                end else if (skip_cnt != 3'd0) begin
                    skip_cnt_n = skip_cnt - 3'd1;
                end else begin
                    case (rx_code)
                        8'hE1: skip_cnt_n = 3'd7;
                        8'hE0: ext_flag_n = 1'b1;
                        8'hF0: brk_flag_n = 1'b1;
                        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ;
                        default: begin
                            ext_flag_n = 1'b0;
                            if (brk_flag) begin
                                brk_flag_n = 1'b0;
`ifdef PS2_REPEAT_SUPPRESS_EN
                                if (last_key == {ext_flag, rx_code}) last_key_n = '0;
`endif
                            end else begin
`ifdef PS2_REPEAT_SUPPRESS_EN
                                if (last_key != {ext_flag, rx_code}) begin
                                    keyboard_n  = rx_code;
                                    key_valid_n = 1'b1;
                                    extended_n  = ext_flag;
                                    last_key_n  = {ext_flag, rx_code};
                                end
`else
                                keyboard_n  = rx_code;
                                key_valid_n = 1'b1;
                                extended_n  = ext_flag;
`endif
                            end
                        end
                    endcase
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ps2_keycode_receiver.sv
// Directed bench for ps2_keycode_receiver: a frame table with expected decodes plus
// hand sequences for timeout, glitch rejection and mid-frame reset.
module tb_ps2_keycode_receiver;

    localparam int unsigned TMO  = 600;
    localparam int unsigned HALF = 20;
    localparam int unsigned GAP  = 30;
    localparam int unsigned LAT  = 12;   // drive of stop-bit fall -> output cycle
`ifdef PS2_REPEAT_SUPPRESS_EN
    localparam bit REP_SUP = 1'b1;
`else
    localparam bit REP_SUP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keyboard;
    logic       key_valid;
    logic       extended;
    logic       frame_error;

    ps2_keycode_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keyboard(keyboard), .key_valid(key_valid), .extended(extended),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] code;
        logic       kv;
        logic       ext;
        logic       fe;
    } ev_t;
    ev_t evq[$];

    // Record every cycle in which any output is non-idle.
    always @(negedge clk) begin
        ev_t e;
        if (!reset && (key_valid || frame_error || extended || keyboard != 8'h00)) begin
            e.at = cyc; e.code = keyboard; e.kv = key_valid; e.ext = extended; e.fe = frame_error;
            evq.push_back(e);
        end
    end

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        bit         ek;
        logic [7:0] ecode;
        bit         eext;
        bit         eerr;
    } vec_t;
    vec_t vecs[$];

    int n_tests = 0;
    int n_fail  = 0;
    int last_fall = 0;

    function automatic vec_t mk(logic [7:0] d, bit bp, bit bs, bit ek, logic [7:0] ec, bit ee, bit er);
        vec_t v;
        v.data = d; v.bad_par = bp; v.bad_stop = bs; v.ek = ek; v.ecode = ec; v.eext = ee; v.eerr = er;
        return v;
    endfunction

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic [7:0] dv;
        dv = d;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(dv[i]);
        ps2_bit((~^dv) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic check(input string name, input bit ek, input logic [7:0] ecode,
                         input bit eext, input bit eerr, input int ecyc);
        ev_t e;
        n_tests++;
        if (!ek && !eerr) begin
            if (evq.size() != 0) begin
                n_fail++;
                $display("FAIL %s: %0d active output cycles (keyboard=%h frame_error=%b), required none",
                         name, evq.size(), evq[0].code, evq[0].fe);
            end
        end else if (evq.size() != 1) begin
            n_fail++;
            $display("FAIL %s: %0d active output cycles, required exactly 1", name, evq.size());
        end else begin
            e = evq[0];
            if (e.kv !== ek || e.fe !== eerr || e.code !== (ek ? ecode : 8'h00) ||
                e.ext !== (ek ? eext : 1'b0) || e.at != ecyc) begin
                n_fail++;
                $display("FAIL %s: got kv=%b code=%h ext=%b err=%b at cycle %0d, required kv=%b code=%h ext=%b err=%b at cycle %0d",
                         name, e.kv, e.code, e.ext, e.fe, e.at, ek, ek ? ecode : 8'h00,
                         ek ? eext : 1'b0, eerr, ecyc);
            end
        end
        evq.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        n_tests++;
        if (keyboard !== 8'h00 || key_valid !== 1'b0 || extended !== 1'b0 || frame_error !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: keyboard=%h key_valid=%b extended=%b frame_error=%b, required all zero",
                     name, keyboard, key_valid, extended, frame_error);
        end
    endtask

    initial begin
        vecs.push_back(mk(8'h1C, 0, 0, 1,        8'h1C, 0, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 0,        8'h00, 0, 0));
        vecs.push_back(mk(8'h1C, 0, 0, 0,        8'h00, 0, 0));
        vecs.push_back(mk(8'hE0, 0, 0, 0,        8'h00, 0, 0));
        vecs.push_back(mk(8'h74, 0, 0, 1,        8'h74, 1, 0));
        vecs.push_back(mk(8'hE0, 0, 0, 0,        8'h00, 0, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 0,        8'h00, 0, 0));
        vecs.push_back(mk(8'h74, 0, 0, 0,        8'h00, 0, 0));
        vecs.push_back(mk(8'h1C, 0, 0, 1,        8'h1C, 0, 0));
        vecs.push_back(mk(8'h24, 1, 0, 0,        8'h00, 0, 1));
        vecs.push_back(mk(8'h24, 0, 0, 1,        8'h24, 0, 0));
        vecs.push_back(mk(8'h1C, 0, 0, 1,        8'h1C, 0, 0));
        vecs.push_back(mk(8'h1C, 0, 0, !REP_SUP, 8'h1C, 0, 0));
        vecs.push_back(mk(8'h1C, 0, 0, !REP_SUP, 8'h1C, 0, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 0,        8'h00, 0, 0));
        vecs.push_back(mk(8'h1C, 0, 0, 0,        8'h00, 0, 0));
        vecs.push_back(mk(8'h1C, 0, 0, 1,        8'h1C, 0, 0));
        vecs.push_back(mk(8'hE1, 0, 0, 0,        8'h00, 0, 0));
        vecs.push_back(mk(8'h14, 0, 0, 0,        8'h00, 0, 0));
        vecs.push_back(mk(8'h77, 0, 0, 0,        8'h00, 0, 0));
        vecs.push_back(mk(8'hE1, 0, 0, 0,        8'h00, 0, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 0,        8'h00, 0, 0));
        vecs.push_back(mk(8'h14, 0, 0, 0,        8'h00, 0, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 0,        8'h00, 0, 0));
        vecs.push_back(mk(8'h77, 0, 0, 0,        8'h00, 0, 0));
        vecs.push_back(mk(8'h43, 0, 0, 1,        8'h43, 0, 0));
        vecs.push_back(mk(8'hAA, 0, 0, 0,        8'h00, 0, 0));
        vecs.push_back(mk(8'hE0, 0, 0, 0,        8'h00, 0, 0));
        vecs.push_back(mk(8'h3C, 0, 1, 0,        8'h00, 0, 1));
        vecs.push_back(mk(8'h74, 0, 0, 1,        8'h74, 0, 0));
        vecs.push_back(mk(8'hFA, 0, 0, 0,        8'h00, 0, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 0,        8'h00, 0, 0));
        vecs.push_back(mk(8'h12, 0, 0, 0,        8'h00, 0, 0));
        vecs.push_back(mk(8'h12, 0, 0, 1,        8'h12, 0, 0));

        repeat (5) @(negedge clk);
        check_idle_outputs("reset_outputs");
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_after_reset", 0, 8'h00, 0, 0, 0);

        foreach (vecs[i]) begin
            send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop);
            check($sformatf("vec%0d_%h", i, vecs[i].data), vecs[i].ek, vecs[i].ecode,
                  vecs[i].eext, vecs[i].eerr, last_fall + LAT);
        end

        // Partial frame of 5 bits, then the clock line stays high.
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (TMO + 40) @(negedge clk);
        check("timeout_error", 0, 8'h00, 0, 1, last_fall + 10 + TMO);

        // 3-cycle clock glitch with data low must not look like a start bit.
        ps2_data = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_no_event", 0, 8'h00, 0, 0, 0);
        send_frame(8'h2D, 0, 0);
        check("after_timeout_2D", 1, 8'h2D, 0, 0, last_fall + LAT);

        // Reset in the middle of a frame, after an E0 prefix.
        send_frame(8'hE0, 0, 0);
        check("prefix_before_reset", 0, 8'h00, 0, 0, 0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("midframe_reset_outputs");
        reset = 1'b0;
        repeat (GAP) @(negedge clk);
        check("midframe_reset_no_error", 0, 8'h00, 0, 0, 0);
        send_frame(8'h5A, 0, 0);
        check("after_reset_5A", 1, 8'h5A, 0, 0, last_fall + LAT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
